// File: rtl/n_ff_sync_filter_if.sv
// Channel bundle for the multi-bit synchronizer/glitch filter.
// The producer drives in; the filter drives the level, edge pulses and changed flag.
interface n_ff_sync_filter_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] in;
  logic [WIDTH-1:0] out;
  logic [WIDTH-1:0] rise;
  logic [WIDTH-1:0] fall;
  logic             changed;

  modport master (
    output in,
    input  out,
    input  rise,
    input  fall,
    input  changed
  );

  modport slave (
    input  in,
    output out,
    output rise,
    output fall,
    output changed
  );
endinterface

// File: rtl/n_ff_sync_filter.sv
// Per-channel N-flop synchronizer followed by a persistence filter and edge detector.
// A channel's output only moves after the synchronized value differs for FILTER_CYCLES edges.
module n_ff_sync_filter #(
  parameter int               WIDTH         = 8,
  parameter int               STAGES        = 2,
  parameter int               FILTER_CYCLES = 4,
  parameter logic [WIDTH-1:0] RESET_VALUE   = '0
) (
  input logic            clk,
  input logic            rst,
  n_ff_sync_filter_if.slave bus
);

  localparam int CW = (FILTER_CYCLES <= 2) ? 1 : $clog2(FILTER_CYCLES);
  localparam logic [CW-1:0] CNT_MAX = CW'(FILTER_CYCLES - 1);

  generate
    if (WIDTH < 1) begin : g_bad_width
      $error("n_ff_sync_filter: WIDTH must be at least 1");
    end
    if (STAGES < 2) begin : g_bad_stages
      $error("n_ff_sync_filter: STAGES must be at least 2");
    end
    if (FILTER_CYCLES < 1) begin : g_bad_filter
      $error("n_ff_sync_filter: FILTER_CYCLES must be at least 1");
    end
    if ($bits(bus.in) != WIDTH) begin : g_bad_if
      $error("n_ff_sync_filter: interface WIDTH does not match module WIDTH");
    end
  endgenerate

  logic [WIDTH-1:0] chain [STAGES];
  logic [WIDTH-1:0] sync;
  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] rise_q;
  logic [WIDTH-1:0] fall_q;
  logic             changed_q;
  logic [CW-1:0]    cnt      [WIDTH];

  logic [WIDTH-1:0] out_nxt;
  logic [WIDTH-1:0] rise_nxt;
  logic [WIDTH-1:0] fall_nxt;
  logic [CW-1:0]    cnt_nxt  [WIDTH];

  assign sync = chain[STAGES-1];

  // Counter saturates at CNT_MAX: reaching it with a still-differing sample commits the change.
  always_comb begin
    out_nxt  = out_q;
    rise_nxt = '0;
    fall_nxt = '0;
    for (int i = 0; i < WIDTH; i++) begin
      cnt_nxt[i] = cnt[i];
      if (sync[i] == out_q[i]) begin
        cnt_nxt[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        out_nxt[i]  = sync[i];
        rise_nxt[i] = sync[i];
        fall_nxt[i] = ~sync[i];
        cnt_nxt[i]  = '0;
      end else begin
        cnt_nxt[i] = cnt[i] + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int s = 0; s < STAGES; s++) begin
        chain[s] <= RESET_VALUE;
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= '0;
      end
      out_q     <= RESET_VALUE;
      rise_q    <= '0;
      fall_q    <= '0;
      changed_q <= 1'b0;
    end else begin
      chain[0] <= bus.in;
      for (int s = 1; s < STAGES; s++) begin
        chain[s] <= chain[s-1];
      end
      for (int i = 0; i < WIDTH; i++) begin
        cnt[i] <= cnt_nxt[i];
      end
      out_q     <= out_nxt;
      rise_q    <= rise_nxt;
      fall_q    <= fall_nxt;
      changed_q <= |{rise_nxt, fall_nxt};
    end
  end

  assign bus.out     = out_q;
  assign bus.rise    = rise_q;
  assign bus.fall    = fall_q;
  assign bus.changed = changed_q;

endmodule

// File: tb/tb_n_ff_sync_filter.sv
// Directed bench for n_ff_sync_filter: a filtered 2-stage instance and an unfiltered 3-stage one.
module tb_n_ff_sync_filter;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  n_ff_sync_filter_if #(.WIDTH(4)) bus_a ();
  n_ff_sync_filter_if #(.WIDTH(4)) bus_b ();

  n_ff_sync_filter #(
    .WIDTH(4), .STAGES(2), .FILTER_CYCLES(3), .RESET_VALUE(4'h0)
  ) dut_a (
    .clk(clk),
    .rst(rst),
    .bus(bus_a.slave)
  );

  n_ff_sync_filter #(
    .WIDTH(4), .STAGES(3), .FILTER_CYCLES(1), .RESET_VALUE(4'h0)
  ) dut_b (
    .clk(clk),
    .rst(rst),
    .bus(bus_b.slave)
  );

  task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges and settle just past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_a(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic c);
    check({tag, ".out"}, bus_a.out, o);
    check({tag, ".rise"}, bus_a.rise, r);
    check({tag, ".fall"}, bus_a.fall, f);
    check({tag, ".chg"}, {3'b000, bus_a.changed}, {3'b000, c});
  endtask

  task automatic check_b(input string tag, input logic [3:0] o, input logic [3:0] r,
                         input logic [3:0] f, input logic c);
    check({tag, ".out"}, bus_b.out, o);
    check({tag, ".rise"}, bus_b.rise, r);
    check({tag, ".fall"}, bus_b.fall, f);
    check({tag, ".chg"}, {3'b000, bus_b.changed}, {3'b000, c});
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    bus_a.in = 4'hF;
    bus_b.in = 4'h0;
    rst      = 1'b1;

    // Reset held two edges with all inputs high
    tick(1);
    check_a("rst_e1", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("rst_e2", 4'h0, 4'h0, 4'h0, 1'b0);
    check_b("rst_b", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    tick(1);
    check_a("post_rst_e1", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(3);
    check_a("all_hi_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("all_hi_e5", 4'hF, 4'hF, 4'h0, 1'b1);
    tick(1);
    check_a("all_hi_e6", 4'hF, 4'h0, 4'h0, 1'b0);

    // All channels fall together
    bus_a.in = 4'h0;
    tick(4);
    check_a("all_lo_e4", 4'hF, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("all_lo_e5", 4'h0, 4'h0, 4'hF, 1'b1);
    tick(3);

    // Single channel step on bit 0
    bus_a.in = 4'h1;
    tick(4);
    check_a("b0_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("b0_e5", 4'h1, 4'h1, 4'h0, 1'b1);
    tick(1);
    check_a("b0_e6", 4'h1, 4'h0, 4'h0, 1'b0);
    tick(2);

    // Two-cycle pulse on bit 1 must be rejected
    bus_a.in = 4'h3;
    tick(2);
    bus_a.in = 4'h1;
    for (int k = 0; k < 8; k++) begin
      check_a("glitch_b1", 4'h1, 4'h0, 4'h0, 1'b0);
      tick(1);
    end

    // Move to out=4'b1000
    bus_a.in = 4'h8;
    tick(5);
    check_a("to_8_e5", 4'h8, 4'h8, 4'h1, 1'b1);
    tick(3);

    // Bit 2 rises and bit 3 falls on the same edge
    bus_a.in = 4'h4;
    tick(4);
    check_a("swap_e4", 4'h8, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("swap_e5", 4'h4, 4'h4, 4'h8, 1'b1);
    tick(1);
    check_a("swap_e6", 4'h4, 4'h0, 4'h0, 1'b0);
    tick(2);

    // Bit 0 goes high; reset lands once its counter has reached 2
    bus_a.in = 4'h5;
    tick(4);
    check_a("midrst_pre", 4'h4, 4'h0, 4'h0, 1'b0);
    rst = 1'b1;
    tick(1);
    check_a("midrst_rst", 4'h0, 4'h0, 4'h0, 1'b0);
    rst = 1'b0;
    tick(1);
    check_a("midrst_e1", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(3);
    check_a("midrst_e4", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_a("midrst_e5", 4'h5, 4'h5, 4'h0, 1'b1);
    tick(2);

    // Unfiltered 3-stage instance: step then single-cycle glitch
    bus_b.in = 4'hA;
    tick(3);
    check_b("b_step_e3", 4'h0, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_b("b_step_e4", 4'hA, 4'hA, 4'h0, 1'b1);
    tick(1);
    check_b("b_step_e5", 4'hA, 4'h0, 4'h0, 1'b0);
    tick(2);

    bus_b.in = 4'hB;
    tick(1);
    bus_b.in = 4'hA;
    tick(2);
    check_b("b_glitch_e3", 4'hA, 4'h0, 4'h0, 1'b0);
    tick(1);
    check_b("b_glitch_e4", 4'hB, 4'h1, 4'h0, 1'b1);
    tick(1);
    check_b("b_glitch_e5", 4'hA, 4'h0, 4'h1, 1'b1);
    tick(1);
    check_b("b_glitch_e6", 4'hA, 4'h0, 4'h0, 1'b0);
    check_a("a_quiet_end", 4'h5, 4'h0, 4'h0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/n_ff_sync_filter.md
N_FF_SYNC_FILTER -- requirements
Module: n_ff_sync_filter

Interface
REQ-001 The block SHALL have parameter WIDTH, default 8: number of independent single-bit channels.
REQ-002 The block SHALL have parameter STAGES, default 2: flip-flop depth of each synchronizer chain.
REQ-003 The block SHALL have parameter FILTER_CYCLES, default 4: consecutive cycles a new synchronized value must persist before it is accepted.
REQ-004 The block SHALL have parameter RESET_VALUE, WIDTH bits, default all-zero: reset value of every chain stage and of out.
REQ-005 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 The block SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-007 The block SHALL have port in, input, WIDTH bits: asynchronous input channels.
REQ-008 The block SHALL have port out, output, WIDTH bits: synchronized, filtered levels, registered.
REQ-009 The block SHALL have port rise, output, WIDTH bits: one-cycle pulse per channel when out[i] goes 0->1, registered.
REQ-010 The block SHALL have port fall, output, WIDTH bits: one-cycle pulse per channel when out[i] goes 1->0, registered.
REQ-011 The block SHALL have port changed, output, 1 bit: registered OR of all rise and fall bits for the same cycle.

Function
REQ-012 Elaboration SHALL fail if WIDTH<1, STAGES<2 or FILTER_CYCLES<1.
REQ-013 Each channel i SHALL pass in[i] through a STAGES-deep flop chain; the last stage is sync[i].
REQ-014 Each channel SHALL have a counter of width max(1,clog2(FILTER_CYCLES)), independent of all other channels.
REQ-015 Per edge, if sync[i]==out[i], the counter SHALL clear to 0 and out[i] SHALL hold.
REQ-016 Per edge, if sync[i]!=out[i] and counter<FILTER_CYCLES-1, the counter SHALL increment and out[i] SHALL hold.
REQ-017 Per edge, if sync[i]!=out[i] and counter==FILTER_CYCLES-1, out[i] SHALL take sync[i] and the counter SHALL clear.
REQ-018 Latency: an input level held stable from the edge that first samples it (edge 1) SHALL appear on out at edge STAGES+FILTER_CYCLES.
REQ-019 A new sync[i] value persisting fewer than FILTER_CYCLES consecutive cycles SHALL be rejected, leaving out[i] and rise/fall unchanged.
REQ-020 rise[i] (fall[i]) SHALL be 1 in exactly the cycle following the edge where out[i] changes 0->1 (1->0), and 0 otherwise.
REQ-021 Simultaneous transitions on multiple channels SHALL produce their rise/fall pulses in the same cycle with changed=1.
REQ-022 With FILTER_CYCLES=1, out SHALL follow sync with one register of delay (no filtering).
REQ-023 The counter SHALL never exceed FILTER_CYCLES-1 (no wrap-around).

Reset
REQ-024 When rst=1 at an edge, all chain stages and out SHALL load RESET_VALUE, and all counters, rise, fall and changed SHALL load 0, overriding all other updates.
REQ-025 rise, fall and changed SHALL remain 0 during reset and in the first cycle after rst deasserts.
REQ-026 A reset asserted mid-filter SHALL discard the pending count; filtering restarts from 0 after release.

Verification
REQ-027 WIDTH=4, STAGES=2, FILTER_CYCLES=3, RESET_VALUE=0: rst=1 for 2 edges with in=4'hF -> out=0, rise=fall=0 during reset and the first cycle after; out=4'hF at edge 5 after release, rise=4'hF and changed=1 for one cycle.
REQ-028 Same configuration: in[0] steps 0->1 and holds -> out[0]=1 at edge 5, rise[0]=1 for exactly one cycle, fall=0.
REQ-029 Same configuration: in[1] high for 2 cycles, then low -> out[1] stays 0, rise[1]=0, changed=0 throughout.
REQ-030 Same configuration, out=4'b1000: in[2] rises and in[3] falls in the same cycle -> rise=4'b0100, fall=4'b1000, changed=1 in the same cycle.
REQ-031 Same configuration: in[0] toggles, rst asserted when counter=2 -> out=0 and counter=0 after the reset edge; no rise pulse; full 5-edge latency after release.
REQ-032 STAGES=3, FILTER_CYCLES=1: any in step -> out updates at edge 4 with matching rise/fall pulse; a 1-cycle input glitch long enough to be captured -> passed through.
